// File: rtl/controle_memoria_tiro.sv
// rtl/controle_memoria_tiro.sv - sequencer/arbiter for the 16x10 shot memory
// Serialises clear-all, per-frame movement sweep and shot spawn onto one RAM port.
module controle_memoria_tiro (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       disparo,
  input  logic [3:0] disparo_x,
  input  logic [3:0] disparo_y,
  input  logic [1:0] disparo_dir,
  input  logic       limpar,
  input  logic [9:0] mem_q,
  output logic       mem_we,
  output logic [3:0] mem_addr,
  output logic [9:0] mem_data,
  output logic       ocupado,
  output logic       pronto,
  output logic       disparo_aceito,
  output logic       disparo_rejeitado,
  output logic [4:0] num_tiros
);

  typedef enum logic [2:0] {LIMPA, OCIOSO, LE, AVALIA, FIM} estado_t;

  estado_t    r_estado;
  logic [3:0] r_i;
  logic       r_op_tick;
  logic       r_limpar_p;
  logic       r_tick_p;
  logic       r_disp_p;
  logic [9:0] r_disp_ent;
  logic [9:0] r_ent;
  logic [4:0] r_cnt;
  logic [4:0] r_num;
  logic       r_mem_we;
  logic [3:0] r_mem_addr;
  logic       r_pronto;
  logic       r_aceito;
  logic       r_rejeitado;

  logic [9:0] w_disp_ent;
  logic       w_disp_novo;
  logic       w_disp_rej;
  logic       w_ef_limpar;
  logic       w_ef_tick;
  logic       w_ef_disp;
  logic [3:0] w_q_x;
  logic [3:0] w_q_y;
  logic [1:0] w_q_dir;
  logic       w_livre;
  logic       w_mov_we;
  logic       w_mov_vivo;
  logic [9:0] w_mov_data;
  logic       w_we_av;
  logic [9:0] w_wdata;

  assign w_disp_ent  = {disparo_x, disparo_y, disparo_dir};
  assign w_disp_novo = disparo && (disparo_dir != 2'b00) && !r_disp_p;
  assign w_disp_rej  = disparo && ((disparo_dir == 2'b00) || r_disp_p);
  assign w_ef_limpar = r_limpar_p | limpar;
  assign w_ef_tick   = r_tick_p | tick;
  assign w_ef_disp   = r_disp_p | w_disp_novo;

  assign w_q_x   = mem_q[9:6];
  assign w_q_y   = mem_q[5:2];
  assign w_q_dir = mem_q[1:0];
  assign w_livre = (w_q_dir == 2'b00);

  // Movement of the entry currently on mem_q; a shot leaving the field is erased.
  always_comb begin
    w_mov_we   = 1'b0;
    w_mov_vivo = 1'b0;
    w_mov_data = 10'd0;
    case (w_q_dir)
      2'b01: begin
        w_mov_we = 1'b1;
        if (w_q_y != 4'd0) begin
          w_mov_data = {w_q_x, w_q_y - 4'd1, w_q_dir};
          w_mov_vivo = 1'b1;
        end
      end
      2'b10: begin
        w_mov_we = 1'b1;
        if (w_q_x != 4'd0) begin
          w_mov_data = {w_q_x - 4'd1, w_q_y, w_q_dir};
          w_mov_vivo = 1'b1;
        end
      end
      2'b11: begin
        w_mov_we = 1'b1;
        if (w_q_x != 4'd15) begin
          w_mov_data = {w_q_x + 4'd1, w_q_y, w_q_dir};
          w_mov_vivo = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Read data only exists during AVALIA, so the write-back is steered from mem_q
  // in that same cycle to commit on the edge that closes it.
  assign w_we_av = (r_estado == AVALIA) && (r_op_tick ? w_mov_we : w_livre);
  assign w_wdata = r_op_tick ? w_mov_data : r_ent;

  assign mem_we            = (r_estado == AVALIA) ? w_we_av : r_mem_we;
  assign mem_addr          = r_mem_addr;
  assign mem_data          = w_we_av ? w_wdata : 10'd0;
  assign ocupado           = (r_estado != OCIOSO);
  assign pronto            = r_pronto;
  assign disparo_aceito    = r_aceito;
  assign disparo_rejeitado = r_rejeitado;
  assign num_tiros         = r_num;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_estado    <= LIMPA;
      r_i         <= 4'd0;
      r_op_tick   <= 1'b0;
      r_limpar_p  <= 1'b0;
      r_tick_p    <= 1'b0;
      r_disp_p    <= 1'b0;
      r_disp_ent  <= 10'd0;
      r_ent       <= 10'd0;
      r_cnt       <= 5'd0;
      r_num       <= 5'd0;
      r_mem_we    <= 1'b1;
      r_mem_addr  <= 4'd0;
      r_pronto    <= 1'b0;
      r_aceito    <= 1'b0;
      r_rejeitado <= 1'b0;
    end else begin
      r_pronto    <= 1'b0;
      r_aceito    <= 1'b0;
      r_rejeitado <= w_disp_rej;

      if (r_estado == LIMPA || r_estado == LE || r_estado == AVALIA) begin
        if (limpar) r_limpar_p <= 1'b1;
        if (tick)   r_tick_p   <= 1'b1;
        if (w_disp_novo) begin
          r_disp_p   <= 1'b1;
          r_disp_ent <= w_disp_ent;
        end
      end

      case (r_estado)
        LIMPA: begin
          if (r_i == 4'd15) begin
            r_estado   <= OCIOSO;
            r_i        <= 4'd0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= 4'd0;
            r_num      <= 5'd0;
          end else begin
            r_i        <= r_i + 4'd1;
            r_mem_addr <= r_i + 4'd1;
          end
        end

        LE: r_estado <= AVALIA;

        AVALIA: begin
          if (r_op_tick) begin
            if (w_mov_vivo) r_cnt <= r_cnt + 5'd1;
            if (r_i == 4'd15) begin
              r_estado <= FIM;
              r_pronto <= 1'b1;
            end else begin
              r_estado   <= LE;
              r_i        <= r_i + 4'd1;
              r_mem_addr <= r_i + 4'd1;
            end
          end else if (w_livre) begin
            r_estado <= FIM;
            r_aceito <= 1'b1;
          end else if (r_i == 4'd15) begin
            r_estado    <= FIM;
            r_rejeitado <= 1'b1;
          end else begin
            r_estado   <= LE;
            r_i        <= r_i + 4'd1;
            r_mem_addr <= r_i + 4'd1;
          end
        end

        OCIOSO, FIM: begin
          if (r_estado == FIM) begin
            if (r_op_tick)     r_num <= r_cnt;
            else if (r_aceito) r_num <= r_num + 5'd1;
          end
          // Fresh requests and pending ones compete with the same priority.
          if (w_ef_limpar) begin
            r_estado    <= LIMPA;
            r_i         <= 4'd0;
            r_mem_addr  <= 4'd0;
            r_mem_we    <= 1'b1;
            r_limpar_p  <= 1'b0;
            r_tick_p    <= 1'b0;
            r_disp_p    <= 1'b0;
            r_rejeitado <= w_disp_rej | w_ef_disp;
          end else if (w_ef_tick) begin
            r_estado   <= LE;
            r_op_tick  <= 1'b1;
            r_i        <= 4'd0;
            r_mem_addr <= 4'd0;
            r_cnt      <= 5'd0;
            r_tick_p   <= 1'b0;
            if (w_disp_novo) begin
              r_disp_p   <= 1'b1;
              r_disp_ent <= w_disp_ent;
            end
          end else if (w_ef_disp) begin
            r_estado   <= LE;
            r_op_tick  <= 1'b0;
            r_i        <= 4'd0;
            r_mem_addr <= 4'd0;
            r_ent      <= r_disp_p ? r_disp_ent : w_disp_ent;
            r_disp_p   <= 1'b0;
          end else begin
            r_estado <= OCIOSO;
          end
        end

        default: r_estado <= LIMPA;
      endcase
    end
  end

endmodule

// File: tb/tb_controle_memoria_tiro.sv
// tb/tb_controle_memoria_tiro.sv - bench for controle_memoria_tiro
// Behavioural RAM, game model, event scoreboard and a vector table.
module tb_controle_memoria_tiro;

  localparam int NV = 32;
  localparam int OP_SPAWN = 0, OP_TICK = 1, OP_LIMPAR = 2;
  localparam int K_PRONTO = 0, K_ACC = 1, K_REJ = 2, K_NONE = 3;

  typedef logic [15:0][9:0] mem_t;
  typedef struct {
    int op; logic [3:0] x; logic [3:0] y; logic [1:0] d;
    int kind; int lat; int idle; int num; mem_t mem;
  } vec_t;
  typedef struct { int kind; int cyc; } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, tick, disparo, limpar;
  logic [3:0] dx, dy;
  logic [1:0] dd;
  logic [9:0] mem_q, mem_data;
  logic       mem_we, ocupado, pronto, aceito, rej;
  logic [3:0] mem_addr;
  logic [4:0] num_tiros;

  controle_memoria_tiro dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .disparo(disparo),
    .disparo_x(dx), .disparo_y(dy), .disparo_dir(dd), .limpar(limpar),
    .mem_q(mem_q), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .ocupado(ocupado), .pronto(pronto), .disparo_aceito(aceito),
    .disparo_rejeitado(rej), .num_tiros(num_tiros)
  );

  logic [9:0] ram [16];
  logic [3:0] ram_aq;
  logic       preload;
  always @(posedge clk) begin
    if (preload) begin
      ram[1] <= 10'h155; ram[2] <= 10'h2AA; ram[3] <= 10'h3FF; ram[4] <= 10'h0C1;
    end
    if (mem_we) ram[mem_addr] <= mem_data;
    ram_aq <= mem_addr;
  end
  assign mem_q = ram[ram_aq];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_vec = 0, n_err = 0;
  ev_t  sb[$];
  vec_t vt[NV];
  logic [9:0] mdl [16];
  int   mdl_num = 0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic sb_hit(input int kind);
    int j; j = -1;
    for (int n = 0; n < sb.size(); n++)
      if (j < 0 && sb[n].kind == kind && sb[n].cyc == cyc) j = n;
    n_vec++;
    if (j >= 0) sb.delete(j);
    else begin
      n_err++;
      $display("FAIL pulse kind %0d: seen in cycle %0d, expected none", kind, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (pronto) sb_hit(K_PRONTO);
      if (aceito) sb_hit(K_ACC);
      if (rej)    sb_hit(K_REJ);
    end
  end

  task automatic sb_drain(input string nm);
    foreach (sb[n]) $display("FAIL %s: pulse kind %0d missing in cycle %0d", nm, sb[n].kind, sb[n].cyc);
    chk(nm, sb.size(), 0);
    sb.delete();
  endtask

  function automatic mem_t ram_flat();
    for (int n = 0; n < 16; n++) ram_flat[n] = ram[n];
  endfunction

  function automatic mem_t mdl_flat();
    for (int n = 0; n < 16; n++) mdl_flat[n] = mdl[n];
  endfunction

  task automatic mdl_tick(output int cnt);
    cnt = 0;
    for (int n = 0; n < 16; n++) begin
      logic [3:0] x, y;
      x = mdl[n][9:6]; y = mdl[n][5:2];
      case (mdl[n][1:0])
        2'b01: if (y == 0) mdl[n] = '0; else begin mdl[n][5:2] = y - 1; cnt++; end
        2'b10: if (x == 0) mdl[n] = '0; else begin mdl[n][9:6] = x - 1; cnt++; end
        2'b11: if (x == 15) mdl[n] = '0; else begin mdl[n][9:6] = x + 1; cnt++; end
        default: ;
      endcase
    end
  endtask

  task automatic mdl_spawn(input logic [3:0] x, input logic [3:0] y, input logic [1:0] d,
                           output int kind, output int lat, output int idle);
    int s; s = -1;
    if (d == 2'b00) begin kind = K_REJ; lat = 0; idle = 0; return; end
    for (int n = 0; n < 16; n++) if (s < 0 && mdl[n][1:0] == 2'b00) s = n;
    if (s >= 0) begin
      mdl[s] = {x, y, d}; mdl_num++;
      kind = K_ACC; lat = 2 * s + 2; idle = 2 * s + 3;
    end else begin
      kind = K_REJ; lat = 32; idle = 33;
    end
  endtask

  task automatic model_op(inout vec_t e);
    int n;
    case (e.op)
      OP_TICK:   begin mdl_tick(n); mdl_num = n; e.kind = K_PRONTO; e.lat = 32; e.idle = 33; end
      OP_LIMPAR: begin for (int m = 0; m < 16; m++) mdl[m] = '0; mdl_num = 0;
                       e.kind = K_NONE; e.lat = 0; e.idle = 16; end
      default:   mdl_spawn(e.x, e.y, e.d, e.kind, e.lat, e.idle);
    endcase
    e.num = mdl_num;
    e.mem = mdl_flat();
  endtask

  task automatic wait_idle(input int k, input int exp_rel, input string nm);
    for (int n = 0; n < 200; n++) begin
      if (!ocupado) break;
      @(negedge clk);
    end
    chk(nm, cyc - k, exp_rel);
  endtask

  task automatic apply(input vec_t v, input int idx);
    int k;
    case (v.op)
      OP_TICK:   tick = 1'b1;
      OP_LIMPAR: limpar = 1'b1;
      default:   begin disparo = 1'b1; dx = v.x; dy = v.y; dd = v.d; end
    endcase
    k = cyc + 1;
    if (v.kind != K_NONE) sb.push_back('{v.kind, k + v.lat});
    @(negedge clk);
    tick = 1'b0; limpar = 1'b0; disparo = 1'b0;
    wait_idle(k, v.idle, $sformatf("v%0d_idle", idx));
    #1;
    chk($sformatf("v%0d_num", idx), num_tiros, v.num);
    chk($sformatf("v%0d_mem", idx), ram_flat(), v.mem);
    sb_drain($sformatf("v%0d_pulse", idx));
    @(negedge clk);
  endtask

  initial begin
    int rel, bad, k, kind, lat, idle, n;
    logic oc15;
    vec_t e;

    for (int n2 = 0; n2 < 16; n2++) mdl[n2] = '0;
    for (int v = 0; v < NV; v++) begin
      e.op = OP_SPAWN; e.x = 4'($urandom_range(0, 15)); e.y = 4'($urandom_range(0, 15));
      e.d = 2'($urandom_range(1, 3));
      if ((v >= 1 && v <= 8) || v == 11 || v == 30) e.op = OP_TICK;
      else if (v == 31) e.op = OP_LIMPAR;
      else if (v == 0)  begin e.x = 4'd5;  e.y = 4'd7; e.d = 2'b01; end
      else if (v == 9)  begin e.x = 4'd15; e.y = 4'd3; e.d = 2'b11; end
      else if (v == 10) begin e.x = 4'd0;  e.y = 4'd9; e.d = 2'b10; end
      else if (v == 12) begin e.x = 4'd4;  e.y = 4'd4; e.d = 2'b00; end
      else if (v == 29) begin e.x = 4'd8;  e.y = 4'd8; e.d = 2'b01; end
      model_op(e);
      vt[v] = e;
    end

    reset_n = 1'b0; tick = 1'b0; disparo = 1'b0; limpar = 1'b0;
    dx = '0; dy = '0; dd = '0; preload = 1'b1;
    repeat (3) @(posedge clk);
    preload = 1'b0;
    @(negedge clk);
    chk("rst_we", mem_we, 1); chk("rst_addr", mem_addr, 0); chk("rst_data", mem_data, 0);
    chk("rst_ocupado", ocupado, 1); chk("rst_num", num_tiros, 0);
    chk("rst_pulses", {pronto, aceito, rej}, 0);
    reset_n = 1'b1;
    rel = cyc; bad = 0; oc15 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!(mem_we === 1'b1 && mem_addr === 4'(i))) bad++;
      if (i == 15) oc15 = ocupado;
      @(negedge clk);
    end
    chk("clear_seq", bad, 0);
    chk("ocupado_c15", oc15, 1);
    chk("ocupado_c16", ocupado, 0);
    chk("clear_cycles", cyc - rel, 16);
    #1;
    chk("clear_num", num_tiros, 0);
    chk("clear_mem", ram_flat(), 0);
    @(negedge clk);

    for (int v = 0; v < NV; v++) begin
      apply(vt[v], v);
      if (v == 0) chk("entry0_const", ram[0], 10'b0101_0111_01);
    end

    // tick and spawn together: sweep first, spawn after; a second spawn bounces.
    tick = 1'b1; disparo = 1'b1; dx = 4'd2; dy = 4'd9; dd = 2'b01;
    k = cyc + 1;
    mdl_tick(n); mdl_num = n;
    sb.push_back('{K_PRONTO, k + 32});
    mdl_spawn(4'd2, 4'd9, 2'b01, kind, lat, idle);
    sb.push_back('{kind, k + 33 + lat});
    @(negedge clk);
    tick = 1'b0; disparo = 1'b0;
    repeat (4) @(negedge clk);
    disparo = 1'b1; dx = 4'd1; dy = 4'd1; dd = 2'b11;
    sb.push_back('{K_REJ, k + 5});
    @(negedge clk);
    disparo = 1'b0;
    wait_idle(k, 33 + idle, "seqa_idle");
    #1;
    chk("seqa_num", num_tiros, mdl_num);
    chk("seqa_mem", ram_flat(), mdl_flat());
    sb_drain("seqa_pulse");
    @(negedge clk);

    // limpar during a sweep runs after FIM and bounces the pending spawn.
    tick = 1'b1;
    k = cyc + 1;
    mdl_tick(n);
    sb.push_back('{K_PRONTO, k + 32});
    sb.push_back('{K_REJ, k + 33});
    @(negedge clk);
    tick = 1'b0;
    repeat (2) @(negedge clk);
    disparo = 1'b1; dx = 4'd7; dy = 4'd7; dd = 2'b10;
    @(negedge clk);
    disparo = 1'b0;
    repeat (2) @(negedge clk);
    limpar = 1'b1;
    @(negedge clk);
    limpar = 1'b0;
    for (int m = 0; m < 16; m++) mdl[m] = '0;
    mdl_num = 0;
    wait_idle(k, 49, "seqb_idle");
    #1;
    chk("seqb_num", num_tiros, 0);
    chk("seqb_mem", ram_flat(), 0);
    sb_drain("seqb_pulse");
    @(negedge clk);

    // Reset in the middle of a sweep aborts it and re-clears the memory.
    e.op = OP_SPAWN; e.x = 4'd3; e.y = 4'd3; e.d = 2'b01;
    model_op(e);
    apply(e, 99);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (6) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_we", mem_we, 1); chk("abort_addr", mem_addr, 0);
    chk("abort_ocupado", ocupado, 1); chk("abort_num", num_tiros, 0);
    @(negedge clk);
    reset_n = 1'b1;
    rel = cyc;
    wait_idle(rel, 16, "abort_idle");
    #1;
    chk("abort_mem", ram_flat(), 0);
    sb_drain("abort_pulse");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/controle_memoria_tiro.md
# controle_memoria_tiro

Sequencer and arbiter for the 16-entry × 10-bit shot memory (synchronous-address RAM: address registered on `clk`, read data valid the following cycle; write on `clk` when `we`). It serialises three requesters onto the single memory port: clear-all, per-frame movement sweep (`tick`) and new-shot spawn (`disparo`). It clears the memory automatically after reset and reports the active-shot count. It sits between game control and `memoria_tiro`.

## Interface
- No parameters. Depth 16 and word 10 bits are fixed.
- Entry format: [9:6] x (0..15), [5:2] y (0..15), [1:0] dir. dir 00 = empty slot, 01 = up (y−1), 10 = left (x−1), 11 = right (x+1).
- `clk` in 1: system clock, rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `tick` in 1: one-cycle pulse; advance all shots.
- `disparo` in 1: one-cycle pulse; spawn a shot.
- `disparo_x`, `disparo_y` in 4 each: spawn position, sampled with `disparo`.
- `disparo_dir` in 2: spawn direction, sampled with `disparo`.
- `limpar` in 1: one-cycle pulse; clear all 16 entries.
- `mem_q` in 10: RAM read data.
- `mem_we` out 1: RAM write enable.
- `mem_addr` out 4: RAM address.
- `mem_data` out 10: RAM write data.
- `ocupado` out 1: 1 in every state except OCIOSO.
- `pronto` out 1: one-cycle pulse at the end of a tick sweep.
- `disparo_aceito` out 1: one-cycle pulse when a spawn is written.
- `disparo_rejeitado` out 1: one-cycle pulse when a spawn is dropped.
- `num_tiros` out 5: active-shot count, 0..16.

## Operation
- States: LIMPA, OCIOSO, LE, AVALIA, FIM. Counter `i` is 4 bits.
- Reset (async) sets state LIMPA, `i`=0, all pending flags 0, `num_tiros`=0, all pulses 0.
- Reset drives `mem_we`=1, `mem_addr`=0, `mem_data`=0, `ocupado`=1.
- LIMPA: 16 cycles with `mem_we`=1, `mem_addr`=`i`, `mem_data`=0. After `i`=15 the FSM goes to OCIOSO and sets `num_tiros`=0.
- LE: `mem_addr`=`i`, `mem_we`=0.
- AVALIA: `mem_addr`=`i` is held and `mem_q` is valid.
- Tick operation, evaluated in AVALIA:
  - dir 00: no write.
  - Exit move (up with y=0, left with x=0, right with x=15): write 0.
  - Any other active entry: write the moved entry and count it.
  - After `i`=15 the FSM goes to FIM. FIM asserts `pronto` and loads `num_tiros` with the count.
- Spawn operation, evaluated in AVALIA:
  - First entry with dir 00 gets {x,y,dir} written; the FSM goes to FIM, which asserts `disparo_aceito` and sets `num_tiros`+1.
  - If no slot is free through `i`=15, FIM asserts `disparo_rejeitado`.
- A `disparo` with dir 00 is rejected without any sweep: `disparo_rejeitado` pulses the next cycle.
- Arbitration:
  - A request sampled in OCIOSO starts immediately. Priority is `limpar` > `tick` > `disparo`; losers are latched as pending.
  - Requests arriving while `ocupado` set pending flags: `limpar_p`, `tick_p`, `disp_p` with its parameters.
  - A repeat `tick` while `tick_p` is set merges into the pending one.
  - A `disparo` while `disp_p` is set is rejected (pulse next cycle); the pending parameters are unchanged.
  - On leaving FIM, pending flags are served in the same priority order; if none is set, the FSM goes to OCIOSO.
  - Starting LIMPA discards `tick_p` and rejects `disp_p` (pulse in LIMPA's first cycle).
- An active reset mid-operation aborts immediately; the memory is re-cleared after release.

## Timing
- A request sampled at edge k starts the operation: LE of entry 0 occupies cycle k..k+1.
- Entry `i`: LE in cycle k+2i, AVALIA in cycle k+2i+1; the write commits at edge k+2i+2.
- Tick: FIM (`pronto`=1) is cycle k+32; OCIOSO is reached at edge k+33 if nothing is pending.
- Spawn into slot s: FIM is cycle k+2s+2 with `disparo_aceito`=1.
- Full memory: `disparo_rejeitado` in cycle k+32.
- LIMPA: 16 cycles; OCIOSO from edge k+16.
- After reset release: OCIOSO after 16 rising edges.
- `num_tiros` changes only at the FIM→next edge and at the end of LIMPA.

## Test plan
- Reset with the RAM preloaded with nonzero entries at addresses 1..4: 16 clear writes follow; all entries read 0; `num_tiros`=0; `ocupado` falls after edge 16.
- `disparo` x=5, y=7, dir=01: entry 0 = 0101_0111_01; `disparo_aceito` in cycle k+2; `num_tiros`=1.
- That shot then 7 `tick`s: y reaches 0. The 8th `tick` writes 0 to entry 0; `num_tiros`=0 and `pronto` occurs at k+32 each sweep.
- Right shot at x=15 plus left shot at x=0: one `tick` kills both; `num_tiros`=0.
- 16 accepted spawns, then a 17th: `disparo_rejeitado` at k+32; memory unchanged.
- `tick` and `disparo` in the same cycle from OCIOSO: the sweep runs first, then the spawn. A second `disparo` during the sweep is rejected next cycle. A `limpar` during the sweep runs after FIM and rejects the pending spawn.
